// File: rtl/tau_gemm_engine_if.sv
// ---------------------------------------------------------------------------
// tau_gemm_engine_if
// Operand and result streams of the bit-serial outer-product GEMM engine.
//   in_valid / in_ready : one k-step (column of A, row of B) per handshake
//   in_a                : ROWS elements of WIDTH bits, element r at [r*WIDTH +: WIDTH]
//   in_b                : COLS elements of WIDTH bits, element c at [c*WIDTH +: WIDTH]
//   out_valid/out_ready : C offered and held until taken
//   out_c               : cell (r,c) at [(r*COLS+c)*ACC_BITS +: ACC_BITS]
// master = operand producer / result consumer, slave = the engine.
// ---------------------------------------------------------------------------
interface tau_gemm_engine_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 8,
  parameter int K_MAX    = 16,
  parameter int ACC_BITS = 2 * WIDTH + $clog2(K_MAX)
);
  logic                           in_valid;
  logic                           in_ready;
  logic [ROWS*WIDTH-1:0]          in_a;
  logic [COLS*WIDTH-1:0]          in_b;
  logic                           out_valid;
  logic                           out_ready;
  logic [ROWS*COLS*ACC_BITS-1:0]  out_c;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c
  );
endinterface

// File: rtl/tau_gemm_engine.sv
// ---------------------------------------------------------------------------
// tau_gemm_engine
// ROWS x COLS grid of bit-serial MAC cells computing C (+)= sum_k a_k (outer) b_k.
// Each accepted k-step is consumed over WIDTH cycles, one bit of b per cycle.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous reset, active low
//   start      begin a job (only honoured while idle)
//   k_len      k-steps in the job, clamped to K_MAX; sampled with start
//   accumulate 1 = continue from current C, 0 = clear C; sampled with start
//   abort      synchronous abort, overrides everything, clears C
//   io         operand/result streams (tau_gemm_engine_if.slave)
//   busy       engine is not idle
// ---------------------------------------------------------------------------
module tau_gemm_engine #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 8,
  parameter int K_MAX    = 16,
  parameter int ACC_BITS = 2 * WIDTH + $clog2(K_MAX),
  parameter int SIGNED   = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  input  logic                       accumulate,
  input  logic                       abort,
  tau_gemm_engine_if.slave           io,
  output logic                       busy
);

  localparam int KW    = $clog2(K_MAX + 1);
  localparam int TW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [KW-1:0]                   klen_q, klen_d;
  logic [KW-1:0]                   step_q, step_d;
  logic [TW-1:0]                   bit_q, bit_d;
  logic [ROWS-1:0][WIDTH-1:0]      a_q, a_d;
  logic [COLS-1:0][WIDTH-1:0]      b_q, b_d;
  logic [CELLS-1:0][ACC_BITS-1:0]  acc_q, acc_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;
  logic [KW-1:0]                   klen_clamped_s;
  logic                            last_bit_s;

  // Extend an operand to accumulator width (sign- or zero-extended) and weight it by 2^sh.
  function automatic logic [ACC_BITS-1:0] weighted_operand(
    input logic [WIDTH-1:0] v,
    input logic [TW-1:0]    sh
  );
    logic [ACC_BITS-1:0] ext;
    ext = {{(ACC_BITS-WIDTH){(SIGNED != 0) && v[WIDTH-1]}}, v};
    return ext << sh;
  endfunction

  // Job depth clamp and last-bit detect for the serial counter.
  always_comb begin
    if (k_len > KW'(K_MAX)) begin
      klen_clamped_s = KW'(K_MAX);
    end else begin
      klen_clamped_s = k_len;
    end
    last_bit_s = (bit_q == TW'(WIDTH - 1));
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    step_d  = step_q;
    bit_d   = bit_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;

    if (abort) begin
      state_d = S_IDLE;
      klen_d  = '0;
      step_d  = '0;
      bit_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            klen_d = klen_clamped_s;
            step_d = '0;
            bit_d  = '0;
            if (!accumulate) begin
              acc_d = '0;
            end else begin
              acc_d = acc_q;
            end
            if (klen_clamped_s == KW'(0)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end

        S_LOAD: begin
          if (io.in_valid && in_ready_q) begin
            a_d     = io.in_a;
            b_d     = io.in_b;
            step_d  = step_q + KW'(1);
            bit_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            state_d = S_LOAD;
          end
        end

        S_COMPUTE: begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (b_q[c][bit_q]) begin
                // In signed mode the MSB of b carries weight -2^(WIDTH-1).
                if ((SIGNED != 0) && last_bit_s) begin
                  acc_d[r*COLS+c] = acc_q[r*COLS+c] - weighted_operand(a_q[r], bit_q);
                end else begin
                  acc_d[r*COLS+c] = acc_q[r*COLS+c] + weighted_operand(a_q[r], bit_q);
                end
              end else begin
                acc_d[r*COLS+c] = acc_q[r*COLS+c];
              end
            end
          end
          if (last_bit_s) begin
            bit_d = '0;
            if (step_q == klen_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            bit_d = bit_q + TW'(1);
          end
        end

        S_DONE: begin
          if (out_valid_q && io.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // in_ready and busy track the state being entered, so they are exact per state.
    // out_valid is offered one cycle after DONE is entered, which makes the result
    // appear WIDTH+1 edges after the last k-step is accepted (the same cadence as a
    // LOAD slot), and drops on the edge that leaves DONE.
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      klen_q      <= '0;
      step_q      <= '0;
      bit_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      step_q      <= step_d;
      bit_q       <= bit_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_c     = acc_q;
  assign busy         = busy_q;

endmodule
